// File: rtl/ni_packet_injector.sv
// Source-side packetiser: turns a (dest, length) request plus a payload stream into
// head/body/tail flits on one credit-checked VC, one packet in flight at a time.
module ni_packet_injector #(
    parameter int VC_NUM         = 2,
    parameter int BUFFER_SIZE    = 8,
    parameter int MESH_SIZE      = 4,
    parameter int DEST_ADDR_SIZE = 3,
    parameter int X_CURRENT      = MESH_SIZE / 2,
    parameter int Y_CURRENT      = MESH_SIZE / 2,
    parameter int MAX_PKT_LEN    = 8,
    parameter int DATA_WIDTH     = 32,
    localparam int LEN_W  = $clog2(MAX_PKT_LEN + 1),
    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    localparam int CRED_W = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [DEST_ADDR_SIZE-1:0] req_x_dest_i,
    input  logic [DEST_ADDR_SIZE-1:0] req_y_dest_i,
    input  logic [LEN_W-1:0]          req_len_i,
    input  logic                      pl_valid_i,
    input  logic [DATA_WIDTH-1:0]     pl_data_i,
    output logic                      pl_ready_o,
    output logic                      flit_valid_o,
    output logic [1:0]                flit_type_o,
    output logic [VC_W-1:0]           flit_vc_o,
    output logic [DEST_ADDR_SIZE-1:0] flit_x_dest_o,
    output logic [DEST_ADDR_SIZE-1:0] flit_y_dest_o,
    output logic [DATA_WIDTH-1:0]     flit_data_o,
    input  logic [VC_NUM-1:0]         credit_i,
    output logic                      err_o
);

    localparam logic [1:0] FT_HEAD     = 2'd0;
    localparam logic [1:0] FT_BODY     = 2'd1;
    localparam logic [1:0] FT_TAIL     = 2'd2;
    localparam logic [1:0] FT_HEADTAIL = 2'd3;

    localparam logic [DEST_ADDR_SIZE-1:0] MAX_COORD = DEST_ADDR_SIZE'(MESH_SIZE - 1);
    localparam logic [LEN_W-1:0]          MAX_LEN   = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0]          ONE_LEN   = LEN_W'(1);
    localparam logic [CRED_W-1:0]         CRED_MAX  = CRED_W'(BUFFER_SIZE);
    localparam logic [CRED_W-1:0]         CRED_ONE  = CRED_W'(1);

    generate
        if (X_CURRENT >= MESH_SIZE || Y_CURRENT >= MESH_SIZE || MAX_PKT_LEN < 1) begin : g_bad_params
            $error("ni_packet_injector: router coordinates or MAX_PKT_LEN out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } state_t;

    state_t                    state_q, state_d;
    logic [DEST_ADDR_SIZE-1:0] x_q, x_d, y_q, y_d;
    logic [LEN_W-1:0]          rem_q, rem_d;
    logic [VC_W-1:0]           vc_q, vc_d;

    logic                      flit_valid_q, flit_valid_d;
    logic [1:0]                flit_type_q, flit_type_d;
    logic [VC_W-1:0]           flit_vc_q, flit_vc_d;
    logic [DEST_ADDR_SIZE-1:0] flit_x_q, flit_x_d, flit_y_q, flit_y_d;
    logic [DATA_WIDTH-1:0]     flit_data_q, flit_data_d;
    logic                      err_q, err_d;

    logic                      issue;
    logic [VC_W-1:0]           issue_vc;
    logic                      pl_take;
    logic                      req_bad;
    logic [VC_NUM-1:0]         vc_has_credit;
    logic [VC_NUM-1:0]         cred_ovf;
    logic                      any_credit;
    logic [VC_W-1:0]           lowest_vc;

    // Per-VC credit counters; issue and return on the same edge cancel out.
    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            logic [CRED_W-1:0] credit_q, credit_d;
            logic              take;
            logic              ovf;

            assign take = issue && (issue_vc == VC_W'(gi));

            always_comb begin
                credit_d = credit_q;
                ovf      = 1'b0;
                if (take && !credit_i[gi]) begin
                    credit_d = credit_q - CRED_ONE;
                end else if (!take && credit_i[gi]) begin
                    if (credit_q == CRED_MAX) begin
                        ovf = 1'b1;
                    end else begin
                        credit_d = credit_q + CRED_ONE;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    credit_q <= CRED_MAX;
                end else begin
                    credit_q <= credit_d;
                end
            end

            assign vc_has_credit[gi] = (credit_q != '0);
            assign cred_ovf[gi]      = ovf;
        end
    endgenerate

    always_comb begin
        any_credit = 1'b0;
        lowest_vc  = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (vc_has_credit[v]) begin
                any_credit = 1'b1;
                lowest_vc  = VC_W'(v);
            end
        end
    end

    assign req_bad = (req_x_dest_i > MAX_COORD) || (req_y_dest_i > MAX_COORD) ||
                     (req_len_i == '0) || (req_len_i > MAX_LEN);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rem_d       = rem_q;
        vc_d        = vc_q;
        issue       = 1'b0;
        issue_vc    = vc_q;
        pl_take     = 1'b0;
        flit_type_d = FT_HEAD;
        flit_x_d    = '0;
        flit_y_d    = '0;
        flit_data_d = '0;
        err_d       = |cred_ovf;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        x_d     = req_x_dest_i;
                        y_d     = req_y_dest_i;
                        rem_d   = req_len_i;
                        state_d = ST_HEAD;
                    end
                end
            end
            ST_HEAD: begin
                if (any_credit) begin
                    issue    = 1'b1;
                    issue_vc = lowest_vc;
                    vc_d     = lowest_vc;
                    flit_x_d = x_q;
                    flit_y_d = y_q;
                    rem_d    = rem_q - ONE_LEN;
                    if (rem_q == ONE_LEN) begin
                        flit_type_d = FT_HEADTAIL;
                        state_d     = ST_IDLE;
                    end else begin
                        flit_type_d = FT_HEAD;
                        state_d     = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                // Locked to vc_q for the rest of the packet, whatever other VCs hold.
                if (vc_has_credit[vc_q] && pl_valid_i) begin
                    issue       = 1'b1;
                    pl_take     = 1'b1;
                    flit_data_d = pl_data_i;
                    rem_d       = rem_q - ONE_LEN;
                    if (rem_q == ONE_LEN) begin
                        flit_type_d = FT_TAIL;
                        state_d     = ST_IDLE;
                    end else begin
                        flit_type_d = FT_BODY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flit_valid_d = issue;
        flit_vc_d    = issue_vc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            rem_q        <= '0;
            vc_q         <= '0;
            flit_valid_q <= 1'b0;
            flit_type_q  <= '0;
            flit_vc_q    <= '0;
            flit_x_q     <= '0;
            flit_y_q     <= '0;
            flit_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rem_q        <= rem_d;
            vc_q         <= vc_d;
            flit_valid_q <= flit_valid_d;
            flit_type_q  <= flit_type_d;
            flit_vc_q    <= flit_vc_d;
            flit_x_q     <= flit_x_d;
            flit_y_q     <= flit_y_d;
            flit_data_q  <= flit_data_d;
            err_q        <= err_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE) && !rst;
    assign pl_ready_o    = pl_take && !rst;
    assign flit_valid_o  = flit_valid_q;
    assign flit_type_o   = flit_type_q;
    assign flit_vc_o     = flit_vc_q;
    assign flit_x_dest_o = flit_x_q;
    assign flit_y_dest_o = flit_y_q;
    assign flit_data_o   = flit_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ni_packet_injector.sv
// Scoreboard bench for ni_packet_injector: expected flits are queued when a request is
// issued and compared field by field as flits leave the DUT.
module tb_ni_packet_injector;

    localparam int VC_NUM = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int MESH_SIZE = 4;
    localparam int DAS = 3;
    localparam int MAX_PKT_LEN = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]     ftype;
        logic           vc;
        logic [DAS-1:0] x;
        logic [DAS-1:0] y;
        logic [DW-1:0]  data;
    } flit_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid_i = 1'b0;
    logic           req_ready_o;
    logic [DAS-1:0] req_x_dest_i = '0;
    logic [DAS-1:0] req_y_dest_i = '0;
    logic [3:0]     req_len_i = '0;
    logic           pl_valid_i = 1'b0;
    logic [DW-1:0]  pl_data_i = '0;
    logic           pl_ready_o;
    logic           flit_valid_o;
    logic [1:0]     flit_type_o;
    logic [0:0]     flit_vc_o;
    logic [DAS-1:0] flit_x_dest_o;
    logic [DAS-1:0] flit_y_dest_o;
    logic [DW-1:0]  flit_data_o;
    logic [VC_NUM-1:0] credit_i = '0;
    logic           err_o;

    ni_packet_injector #(
        .VC_NUM(VC_NUM), .BUFFER_SIZE(BUFFER_SIZE), .MESH_SIZE(MESH_SIZE),
        .DEST_ADDR_SIZE(DAS), .MAX_PKT_LEN(MAX_PKT_LEN), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_x_dest_i(req_x_dest_i), .req_y_dest_i(req_y_dest_i), .req_len_i(req_len_i),
        .pl_valid_i(pl_valid_i), .pl_data_i(pl_data_i), .pl_ready_o(pl_ready_o),
        .flit_valid_o(flit_valid_o), .flit_type_o(flit_type_o), .flit_vc_o(flit_vc_o),
        .flit_x_dest_o(flit_x_dest_o), .flit_y_dest_o(flit_y_dest_o),
        .flit_data_o(flit_data_o), .credit_i(credit_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;
    flit_t sb[$];
    logic [DW-1:0] pl_q[$];
    int stamps[$];
    int cyc = 0;
    int flits_seen = 0;
    int err_cnt = 0;
    int hs_cnt = 0;
    logic pl_gate = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Payload source: presents the head of pl_q whenever the gate is open.
    always @(negedge clk) begin
        pl_valid_i = pl_gate && (pl_q.size() > 0);
        pl_data_i  = (pl_q.size() > 0) ? pl_q[0] : '0;
    end

    always @(posedge clk) begin
        cyc++;
        if (pl_valid_i && pl_ready_o) begin
            hs_cnt++;
            void'(pl_q.pop_front());
        end
    end

    always @(negedge clk) begin
        flit_t e;
        if (err_o) err_cnt++;
        if (flit_valid_o) begin
            flits_seen++;
            stamps.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_flit", 64'(flit_type_o), 64'hdead);
            end else begin
                e = sb.pop_front();
                check("flit_type", 64'(flit_type_o), 64'(e.ftype));
                check("flit_vc", 64'(flit_vc_o), 64'(e.vc));
                check("flit_x", 64'(flit_x_dest_o), 64'(e.x));
                check("flit_y", 64'(flit_y_dest_o), 64'(e.y));
                check("flit_data", 64'(flit_data_o), 64'(e.data));
                $display("flit type=%0d vc=%0d x=%0d y=%0d data=%0h", flit_type_o, flit_vc_o,
                         flit_x_dest_o, flit_y_dest_o, flit_data_o);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_pkt(input int x, input int y, input int len, input int vc,
                            input logic [DW-1:0] base);
        flit_t f;
        f.ftype = (len == 1) ? 2'd3 : 2'd0;
        f.vc    = 1'(vc);
        f.x     = DAS'(x);
        f.y     = DAS'(y);
        f.data  = '0;
        sb.push_back(f);
        for (int i = 1; i < len; i++) begin
            f.ftype = (i == len - 1) ? 2'd2 : 2'd1;
            f.x     = '0;
            f.y     = '0;
            f.data  = base + DW'(i);
            sb.push_back(f);
            pl_q.push_back(f.data);
        end
    endtask

    task automatic send_req(input int x, input int y, input int len);
        int t = 0;
        while (!req_ready_o && t < 200) begin
            step();
            t++;
        end
        check("req_ready_timeout", 64'(t < 200), 64'd1);
        req_valid_i  = 1'b1;
        req_x_dest_i = DAS'(x);
        req_y_dest_i = DAS'(y);
        req_len_i    = 4'(len);
        $display("req x=%0d y=%0d len=%0d", x, y, len);
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_flits(input int n);
        int t = 0;
        while (flits_seen < n && t < 300) begin
            step();
            t++;
        end
        check("wait_flits", 64'(flits_seen >= n), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            step();
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        step(2);
    endtask

    task automatic pulse_credit(input int vc, input int n);
        for (int i = 0; i < n; i++) begin
            credit_i = '0;
            credit_i[vc] = 1'b1;
            step();
            credit_i = '0;
        end
    endtask

    initial begin
        int s0, c0, e0, h0;
        step(3);
        check("rst_flit_valid", 64'(flit_valid_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_pl_ready", 64'(pl_ready_o), 64'd0);
        rst = 1'b0;
        step();
        check("rst_req_ready", 64'(req_ready_o), 64'd1);

        // 1: L=4 to (3,1), payload always valid -> 4 consecutive flits on vc0
        s0 = stamps.size();
        push_pkt(3, 1, 4, 0, 32'h9);
        send_req(3, 1, 4);
        drain();
        check("t1_consecutive", 64'(stamps[s0+3] - stamps[s0]), 64'd3);

        // 2: L=1 to (0,0) -> HEADTAIL, no payload handshake (vc0 4->3)
        h0 = hs_cnt;
        push_pkt(0, 0, 1, 0, 32'h0);
        send_req(0, 0, 1);
        drain();
        check("t2_no_pl_ready", 64'(hs_cnt - h0), 64'd0);

        // 3: drain vc0 (3->0), next packet on vc1; vc0 return mid-packet ignored
        push_pkt(1, 2, 3, 0, 32'h100);
        send_req(1, 2, 3);
        drain();
        pl_gate = 1'b0;
        c0 = flits_seen;
        push_pkt(2, 3, 3, 1, 32'h200);
        send_req(2, 3, 3);
        wait_flits(c0 + 1);
        pulse_credit(0, 1);
        pl_gate = 1'b1;
        drain();

        // 4a: payload gap of 3 cycles after head (vc0 refilled to 8)
        pulse_credit(0, 7);
        pl_gate = 1'b0;
        c0 = flits_seen;
        push_pkt(1, 1, 3, 0, 32'h300);
        send_req(1, 1, 3);
        wait_flits(c0 + 1);
        step(3);
        check("t4_gap_no_flit", 64'(flits_seen), 64'(c0 + 1));
        pl_gate = 1'b1;
        drain();

        // 4b: vc0 5->1, then head takes the last credit and the body stalls on credit
        push_pkt(0, 3, 4, 0, 32'h400);
        send_req(0, 3, 4);
        drain();
        c0 = flits_seen;
        push_pkt(3, 3, 3, 0, 32'h500);
        send_req(3, 3, 3);
        wait_flits(c0 + 1);
        step(4);
        check("t4_credit_stall", 64'(flits_seen), 64'(c0 + 1));
        pulse_credit(0, 1);
        step(4);
        check("t4_one_flit_per_credit", 64'(flits_seen), 64'(c0 + 2));
        pulse_credit(0, 1);
        drain();

        // 5: illegal requests -> no flit, one err pulse each, still ready
        for (int k = 0; k < 4; k++) begin
            int bx, by, bl;
            bx = (k == 0) ? MESH_SIZE : 1;
            by = (k == 1) ? MESH_SIZE : 1;
            bl = (k == 2) ? 0 : ((k == 3) ? MAX_PKT_LEN + 1 : 2);
            e0 = err_cnt;
            c0 = flits_seen;
            send_req(bx, by, bl);
            step(3);
            check("t5_err_once", 64'(err_cnt - e0), 64'd1);
            check("t5_no_flit", 64'(flits_seen), 64'(c0));
            check("t5_ready", 64'(req_ready_o), 64'd1);
        end

        // 5b: vc1 5->8 with no error, one more return overflows
        e0 = err_cnt;
        pulse_credit(1, 3);
        step(2);
        check("t5b_no_err", 64'(err_cnt - e0), 64'd0);
        pulse_credit(1, 1);
        step(2);
        check("t5b_ovf_err", 64'(err_cnt - e0), 64'd1);

        // 6: reset after head of L=5 on vc1 (vc0 empty)
        pl_gate = 1'b0;
        c0 = flits_seen;
        push_pkt(2, 2, 5, 1, 32'h600);
        send_req(2, 2, 5);
        wait_flits(c0 + 1);
        rst = 1'b1;
        step(2);
        check("t6_rst_valid", 64'(flit_valid_o), 64'd0);
        check("t6_rst_err", 64'(err_o), 64'd0);
        check("t6_rst_pl_ready", 64'(pl_ready_o), 64'd0);
        sb.delete();
        pl_q.delete();
        pl_gate = 1'b1;
        rst = 1'b0;
        step();
        check("t6_ready_after_rst", 64'(req_ready_o), 64'd1);
        check("t6_no_flit_after_rst", 64'(flits_seen), 64'(c0 + 1));
        s0 = stamps.size();
        push_pkt(1, 0, 8, 0, 32'h700);
        send_req(1, 0, 8);
        drain();
        check("t6_full_vc0_consecutive", 64'(stamps[s0+7] - stamps[s0]), 64'd7);
        push_pkt(0, 1, 1, 1, 32'h0);
        send_req(0, 1, 1);
        drain();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
